// File: rtl/traffic_light_ctrl_if.sv
// Lamp, demand and display signals between the traffic light controller and the board.
// master = controller side, slave = sensors/lamp drivers/display side.
interface traffic_light_ctrl_if #(
    parameter int TSEC_W = 5
);
    logic              side_req;
    logic              ped_req;
    logic              night;
    logic              main_r;
    logic              main_y;
    logic              main_g;
    logic              side_r;
    logic              side_y;
    logic              side_g;
    logic              tick;
    logic [TSEC_W-1:0] tsecond;
    logic [2:0]        phase;

    modport master (
        input  side_req, ped_req, night,
        output main_r, main_y, main_g, side_r, side_y, side_g,
        output tick, tsecond, phase
    );

    modport slave (
        output side_req, ped_req, night,
        input  main_r, main_y, main_g, side_r, side_y, side_g,
        input  tick, tsecond, phase
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road six-phase traffic light controller with built-in tick prescaler; optional NIGHT_FLASH_EN.
// Latency: phase/lamps change one clk after the tick that triggers the transition.
// Backpressure: none; requests are latched into a pending flag until side green is served.
module traffic_light_ctrl #(
    parameter int CLK_DIV    = 50000000,
    parameter int TSEC_W     = 5,
    parameter int GREEN_MAIN = 10,
    parameter int GREEN_SIDE = 6,
    parameter int YELLOW     = 3,
    parameter int ALLRED     = 1
) (
    input logic                   clk,
    input logic                   reset,
    traffic_light_ctrl_if.master  lights
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        CLR1   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        CLR2   = 3'd5,
        FLASH  = 3'd6,
        BAD7   = 3'd7
    } phase_e;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TSEC_W-1:0] LAST_GM  = TSEC_W'(GREEN_MAIN - 1);
    localparam logic [TSEC_W-1:0] LAST_GS  = TSEC_W'(GREEN_SIDE - 1);
    localparam logic [TSEC_W-1:0] LAST_Y   = TSEC_W'(YELLOW - 1);
    localparam logic [TSEC_W-1:0] LAST_AR  = TSEC_W'(ALLRED - 1);

    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic [2:0]        phase_q;
    phase_e            cur;
    phase_e            phase_d;
    phase_e            succ;
    logic [TSEC_W-1:0] tsec_q;
    logic [TSEC_W-1:0] tsec_d;
    logic [TSEC_W-1:0] last;
    logic              exit_ok;
    logic              legal;
    logic              enter_side;
    logic              pending_q;

    // Prescaler: free-running 0..CLK_DIV-1, tick on the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign tick = (div_q == DIV_LAST);

    // The register holds the raw encoding so unused codes can be recognised and recovered.
    assign cur = phase_e'(phase_q);

`ifdef NIGHT_FLASH_EN
    logic flash_q;
    logic flash_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_q <= 1'b0;
        end else begin
            flash_q <= flash_d;
        end
    end
`else
    logic night_unused;
    assign night_unused = lights.night;
`endif

    // Per-phase duration, successor and exit condition.
    always_comb begin
        last    = '0;
        succ    = MAIN_G;
        exit_ok = 1'b1;
        legal   = 1'b1;
        case (cur)
            MAIN_G: begin
                last    = LAST_GM;
                succ    = MAIN_Y;
                exit_ok = pending_q;
            end
            MAIN_Y: begin
                last = LAST_Y;
                succ = CLR1;
            end
            CLR1: begin
                last = LAST_AR;
                succ = SIDE_G;
            end
            SIDE_G: begin
                last = LAST_GS;
                succ = SIDE_Y;
            end
            SIDE_Y: begin
                last = LAST_Y;
                succ = CLR2;
            end
            CLR2: begin
                last = LAST_AR;
                succ = MAIN_G;
            end
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                succ    = CLR2;
                exit_ok = ~lights.night;
            end
`endif
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Next state; illegal encodings recover on the next clk regardless of tick.
    always_comb begin
        phase_d = cur;
        tsec_d  = tsec_q;
`ifdef NIGHT_FLASH_EN
        flash_d = flash_q;
`endif
        if (!legal) begin
            phase_d = MAIN_G;
            tsec_d  = '0;
        end else if (tick) begin
`ifdef NIGHT_FLASH_EN
            if (cur == MAIN_G && lights.night) begin
                phase_d = FLASH;
                tsec_d  = '0;
                flash_d = 1'b1;
            end else if (cur == FLASH) begin
                if (exit_ok) begin
                    phase_d = succ;
                    tsec_d  = '0;
                end else begin
                    flash_d = ~flash_q;
                end
            end else
`endif
            if (tsec_q == last) begin
                if (exit_ok) begin
                    phase_d = succ;
                    tsec_d  = '0;
                end
            end else begin
                tsec_d = tsec_q + TSEC_W'(1);
            end
        end
    end

    assign enter_side = (phase_d == SIDE_G) && (cur != SIDE_G);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= MAIN_G;
            tsec_q  <= '0;
        end else begin
            phase_q <= phase_d;
            tsec_q  <= tsec_d;
        end
    end

    // Entering side green consumes the demand, even against a same-clk request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else if (enter_side) begin
            pending_q <= 1'b0;
        end else if (lights.side_req || lights.ped_req) begin
            pending_q <= 1'b1;
        end
    end

    always_comb begin
        lights.main_r = 1'b0;
        lights.main_y = 1'b0;
        lights.main_g = 1'b0;
        lights.side_r = 1'b0;
        lights.side_y = 1'b0;
        lights.side_g = 1'b0;
        case (cur)
            MAIN_G: begin
                lights.main_g = 1'b1;
                lights.side_r = 1'b1;
            end
            MAIN_Y: begin
                lights.main_y = 1'b1;
                lights.side_r = 1'b1;
            end
            SIDE_G: begin
                lights.main_r = 1'b1;
                lights.side_g = 1'b1;
            end
            SIDE_Y: begin
                lights.main_r = 1'b1;
                lights.side_y = 1'b1;
            end
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                lights.main_y = flash_q;
                lights.side_r = flash_q;
            end
`endif
            default: begin
                lights.main_r = 1'b1;
                lights.side_r = 1'b1;
            end
        endcase
    end

    assign lights.tick    = tick;
    assign lights.tsecond = tsec_q;
    assign lights.phase   = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus random demand, checked every clk against a phase-table model.
module tb_traffic_light_ctrl;
    localparam int CLK_DIV = 4;
    localparam int TSEC_W  = 5;
`ifdef NIGHT_FLASH_EN
    localparam bit NIGHT_ON = 1'b1;
`else
    localparam bit NIGHT_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    bit   inj_ill = 1'b0;

    int m_div, m_ph, m_t;
    bit m_pend, m_flash;

    traffic_light_ctrl_if #(.TSEC_W(TSEC_W)) lights ();

    traffic_light_ctrl #(
        .CLK_DIV(CLK_DIV), .TSEC_W(TSEC_W), .GREEN_MAIN(3),
        .GREEN_SIDE(2), .YELLOW(2), .ALLRED(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lights(lights)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Phase durations in ticks: MAIN_G, MAIN_Y, CLR1, SIDE_G, SIDE_Y, CLR2.
    function automatic int dur_of(input int ph);
        case (ph)
            0: return 3;
            1: return 2;
            2: return 1;
            3: return 2;
            4: return 2;
            default: return 1;
        endcase
    endfunction

    // {main_r, main_y, main_g, side_r, side_y, side_g}
    function automatic int exp_lamps(input int ph, input bit fl);
        case (ph)
            0: return 6'b001_100;
            1: return 6'b010_100;
            3: return 6'b100_001;
            4: return 6'b100_010;
            6: return fl ? 6'b010_100 : 6'b000_000;
            default: return 6'b100_100;
        endcase
    endfunction

    function automatic int dut_lamps();
        return int'({lights.main_r, lights.main_y, lights.main_g,
                     lights.side_r, lights.side_y, lights.side_g});
    endfunction

    always @(posedge clk) begin
        int old;
        bit tk;
        bit req;
        if (reset) begin
            m_div = 0; m_ph = 0; m_t = 0; m_pend = 1'b0; m_flash = 1'b0;
        end else begin
            tk  = (m_div == CLK_DIV - 1);
            req = lights.side_req | lights.ped_req;
            old = m_ph;
            if (inj_ill) begin
                m_ph = 0; m_t = 0;
            end else if (tk) begin
                if (NIGHT_ON && m_ph == 0 && lights.night) begin
                    m_ph = 6; m_t = 0; m_flash = 1'b1;
                end else if (m_ph == 6) begin
                    if (!lights.night) begin
                        m_ph = 5; m_t = 0;
                    end else begin
                        m_flash = !m_flash;
                    end
                end else if (m_t == dur_of(m_ph) - 1) begin
                    if (m_ph != 0 || m_pend) begin
                        m_ph = (m_ph + 1) % 6; m_t = 0;
                    end
                end else begin
                    m_t++;
                end
            end
            if (m_ph == 3 && old != 3) m_pend = 1'b0;
            else if (req) m_pend = 1'b1;
            m_div = (m_div + 1) % CLK_DIV;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("cmp_phase", int'(lights.phase), m_ph);
            chk("cmp_tsecond", int'(lights.tsecond), m_t);
            chk("cmp_tick", int'(lights.tick), int'(m_div == CLK_DIV - 1));
            chk("cmp_lamps", dut_lamps(), exp_lamps(m_ph, m_flash));
            chk("no_conflict", int'((lights.main_g | lights.main_y) & (lights.side_g | lights.side_y)), 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        lights.side_req = 1'b0;
        lights.ped_req  = 1'b0;
        lights.night    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic side_pulse();
        lights.side_req = 1'b1;
        @(negedge clk);
        lights.side_req = 1'b0;
    endtask

    task automatic wait_phase(input bit eq, input int ph, input int budget, output int steps);
        steps = 0;
        while (((int'(lights.phase) == ph) != eq) && steps < budget) begin
            @(negedge clk);
            steps++;
        end
    endtask

    task automatic wait_tick(input int budget, output int steps);
        steps = 0;
        while (!lights.tick && steps < budget) begin
            @(negedge clk);
            steps++;
        end
    endtask

    initial begin
        int s;
        int cnt;
        reset = 1'b1;
        lights.side_req = 1'b0;
        lights.ped_req  = 1'b0;
        lights.night    = 1'b0;
        repeat (2) @(negedge clk);

        // Idle: main green forever, tsecond saturates.
        do_reset();
        chk_en = 1'b1;
        chk("rst_phase", int'(lights.phase), 0);
        chk("rst_tsecond", int'(lights.tsecond), 0);
        chk("rst_tick", int'(lights.tick), 0);
        chk("rst_lamps", dut_lamps(), 6'b001_100);
        cnt = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 3)   chk("s1_tick_first", int'(lights.tick), 1);
            if (n == 4)   chk("s1_tick_after", int'(lights.tick), 0);
            if (n == 6)   chk("s1_tsec_1", int'(lights.tsecond), 1);
            if (n == 10)  chk("s1_tsec_2", int'(lights.tsecond), 2);
            if (n == 399) chk("s1_tsec_sat", int'(lights.tsecond), 2);
            if (lights.main_g && lights.side_r) cnt++;
        end
        chk("s1_main_g_cycles", cnt, 400);

        // One side request: full side cycle of 8 ticks, then idle.
        do_reset();
        side_pulse();
        wait_phase(1'b0, 0, 100, s);
        chk("s2_first_exit_clk", s + 1, 12);
        wait_phase(1'b1, 0, 100, s);
        chk("s2_side_cycle_clks", s, 32);
        wait_phase(1'b0, 0, 40, s);
        chk("s2_no_repeat", s, 40);

        // Request coinciding with SIDE_G entry is absorbed.
        do_reset();
        side_pulse();
        wait_phase(1'b1, 2, 100, s);
        chk("s3a_reach_clr1", s, 19);
        wait_tick(8, s);
        chk("s3a_clr1_tick", s, 3);
        lights.ped_req = 1'b1;
        @(negedge clk);
        lights.ped_req = 1'b0;
        chk("s3a_in_side_g", int'(lights.phase), 3);
        wait_phase(1'b1, 0, 100, s);
        chk("s3a_return", s, 20);
        wait_phase(1'b0, 0, 60, s);
        chk("s3a_single_cycle", s, 60);

        // Request one clk after entry is served again.
        do_reset();
        side_pulse();
        wait_phase(1'b1, 2, 100, s);
        wait_tick(8, s);
        @(negedge clk);
        chk("s3b_in_side_g", int'(lights.phase), 3);
        lights.ped_req = 1'b1;
        @(negedge clk);
        lights.ped_req = 1'b0;
        wait_phase(1'b1, 0, 100, s);
        chk("s3b_return", s, 19);
        wait_phase(1'b0, 0, 60, s);
        chk("s3b_second_cycle", s, 12);

        // Reset in SIDE_Y aborts with no clearance.
        do_reset();
        side_pulse();
        wait_phase(1'b1, 4, 100, s);
        do_reset();
        chk("s4_phase", int'(lights.phase), 0);
        chk("s4_lamps", dut_lamps(), 6'b001_100);
        chk("s4_tsecond", int'(lights.tsecond), 0);
        chk("s4_tick", int'(lights.tick), 0);
        wait_tick(10, s);
        chk("s4_next_tick", s, 3);

        // Illegal encoding recovers to MAIN_G.
        do_reset();
        side_pulse();
        wait_phase(1'b1, 1, 100, s);
        force dut.phase_q = 3'd7;
        inj_ill = 1'b1;
        #1;
        release dut.phase_q;
        @(posedge clk);
        #2;
        inj_ill = 1'b0;
        @(negedge clk);
        chk("s5_phase", int'(lights.phase), 0);
        chk("s5_tsecond", int'(lights.tsecond), 0);
        chk("s5_lamps", dut_lamps(), 6'b001_100);

        // Night request.
        do_reset();
        lights.night = 1'b1;
`ifdef NIGHT_FLASH_EN
        wait_phase(1'b1, 6, 20, s);
        chk("s6_flash_entry", s, 4);
        chk("s6_flash_1", dut_lamps(), 6'b010_100);
        wait_tick(8, s);
        @(negedge clk);
        chk("s6_flash_0", dut_lamps(), 6'b000_000);
        wait_tick(8, s);
        @(negedge clk);
        chk("s6_flash_1b", dut_lamps(), 6'b010_100);
        lights.night = 1'b0;
        wait_phase(1'b1, 5, 20, s);
        chk("s6_to_clr2", int'(lights.phase), 5);
        wait_phase(1'b1, 0, 20, s);
        chk("s6_clr2_clks", s, 4);
`else
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (lights.main_g) cnt++;
        end
        chk("s6_night_ignored", cnt, 40);
`endif
        lights.night = 1'b0;

        // Random demand, night and resets against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            lights.side_req = ($urandom_range(0, 39) == 0);
            lights.ped_req  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) lights.night = ~lights.night;
            reset = ($urandom_range(0, 1499) == 0);
        end
        reset = 1'b0;
        lights.side_req = 1'b0;
        lights.ped_req  = 1'b0;
        lights.night    = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
